// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared multiply/divide op and FSM state encodings
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Bit 0 of the op distinguishes the unsigned variant.
  function automatic logic is_signed_op(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage request and HI/LO result bundle for muldiv_unit
interface muldiv_if #(parameter int WIDTH = 32);
  import mips_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_nxt  = acc_hi;
    lo_nxt  = acc_lo;
    if (is_div) begin
      // Remainder stays below the divisor, so the top bit of diff is the borrow.
      if (!diff[WIDTH]) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module muldiv_unit
  import mips_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_nxt;
  logic               load, step_en, fix_en, mt_en;
  logic [CW-1:0]      cnt;
  md_op_e             op_q;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo, a_raw, hi_q, lo_q;
  logic               neg_res, neg_rem, divz, done_q;
  logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               sgn;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    mt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (md.start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          mt_en = 1'b1;
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn   = is_signed_op(md.op);
    abs_a = (sgn && md.a[WIDTH-1]) ? -md.a : md.a;
    abs_b = (sgn && md.b[WIDTH-1]) ? -md.b : md.b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_q[1]),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Divide-by-zero overrides whatever the iterations produced.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (!op_q[1]) begin
      if (neg_res) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (divz) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_lo = neg_res ? -acc_lo : acc_lo;
      fix_hi = neg_rem ? -acc_hi : acc_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= MD_MULT;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      divz    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fix_en;
      if (load) begin
        op_q    <= md.op;
        cnt     <= CW'(WIDTH - 1);
        acc_hi  <= '0;
        acc_lo  <= md.op[1] ? abs_a : abs_b;
        opnd    <= md.op[1] ? abs_b : abs_a;
        a_raw   <= md.a;
        neg_res <= sgn & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
        neg_rem <= sgn & md.a[WIDTH-1];
        divz    <= md.op[1] & (md.b == '0);
      end
      if (step_en) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (fix_en) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
      if (mt_en) begin
        if (md.we_hi) hi_q <= md.wd;
        if (md.we_lo) lo_q <= md.wd;
      end
    end
  end

  assign md.busy = (state != IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the pipelined MIPS32 core, owning the architectural HI/LO registers. It sits beside the EX stage: it takes source operands read from the register file (rs/rt), runs MULT/MULTU/DIV/DIVU over 33 clock cycles, and supplies HI/LO to the EX-stage mux so MFHI/MFLO results flow to writeback and the register file write port. `busy` drives the hazard unit's stall for any HI/LO access issued while an operation is in flight.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits; iteration count equals `WIDTH`.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  launch the operation in `op` with operands `a` and `b`.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs value (multiplicand / dividend).
- `b`  in  WIDTH  rt value (multiplier / divisor).
- `we_hi`  in  1  MTHI write strobe.
- `we_lo`  in  1  MTLO write strobe.
- `wd`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset is asynchronous, active-low: state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, iteration counter 0.
- FSM states:
  - IDLE: `start`=1 latches `op`, `a`, `b`, takes absolute values for signed ops, records result signs, loads the counter with WIDTH-1, and moves to CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; leaves for FIX when the counter reaches 0.
  - FIX: applies sign correction, writes `hi`/`lo`, pulses `done`, returns to IDLE.
- Result definitions:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero, detected at start:
  - The iterations still run, so latency is unchanged.
  - FIX writes hi=`a`, lo=all-ones, for both DIV and DIVU.
- DIV of 0x8000_0000 by 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No trap.
- `start` while `busy`=1 is ignored. The op in flight is unaffected.
- `we_hi`/`we_lo` are honoured only in IDLE with `start`=0:
  - The targeted register takes `wd` on that edge.
  - Both strobes set together write both registers.
  - Strobes while busy are dropped; the hazard unit must stall MTHI/MTLO instead.
- `start` and a write strobe on the same IDLE edge: `start` wins and the write is dropped.
- `hi`/`lo` hold their previous values throughout CALC and change only in FIX or on an MTHI/MTLO write.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result becomes visible.

## Timing
- `start` sampled at edge N, IDLE → CALC.
- CALC occupies edges N+1 … N+WIDTH. FIX occurs at edge N+WIDTH+1.
- `busy` is high from after edge N to after edge N+WIDTH+1, i.e. 33 cycles for WIDTH=32.
- `done` and new `hi`/`lo` are visible in the cycle after edge N+WIDTH+1. `done` is high for exactly one cycle, and `busy` is already 0 in that cycle.
- Back-to-back: `start` may be asserted in the cycle `done` is high. That op is accepted at the following edge, so there is no dead cycle.
- `busy`, `done`, `hi`, `lo` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `mips_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - FSM state encoding IDLE/CALC/FIX.
- One sub-module is natural: `muldiv_step`, the combinational single-iteration datapath (shift-add or trial subtract selected by op class). The FSM, counter, sign capture and HI/LO registers stay in `muldiv_unit`.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → after 33 busy cycles, `done` pulses; hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT −7 × 3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. DIV −7 ÷ 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 100 ÷ 0 → hi=100, lo=0xFFFF_FFFF, same latency. DIV 0x8000_0000 ÷ −1 → lo=0x8000_0000, hi=0.
- MTHI 0x1234 in IDLE → hi=0x1234 next cycle. `we_lo` and `start` asserted together while busy → both ignored; the result matches a lone op.
- `rst_n` low at CALC iteration 10 → hi=lo=0, busy=0 immediately. After release, a new MULTU 3×5 gives lo=15, hi=0.
- Back-to-back: second `start` asserted in the `done` cycle → accepted; its `done` arrives exactly 34 cycles after the first `done`.
